cache_mem_responder: RTL and testbench
======================================

// Module: cache_mem_responder
// PURPOSE
//  Memory-side responder for the req/gnt/rvalid data-memory protocol driven by the cache's mem_* port.
//  Holds a byte-enabled word RAM and answers one transaction at a time.
//  Grant and response latencies are configurable, so cache miss and write paths can be stressed.
//  Sits between the cache mem_* outputs and on-chip RAM; also used as a bench memory model.
// PARAMETERS
//  DEPTH_WORDS     1024          RAM depth in 32-bit words
//  BASE_ADDR       32'h0000_0000 byte address of word 0; must be word aligned
//  GNT_LATENCY     0             cycles req_i must be held before gnt_o (0 = same cycle)
//  RVALID_LATENCY  1             cycles from the grant cycle to the rvalid_o pulse (>=1)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-low reset
//  mem_addr_i    in   32  byte address; bits [1:0] ignored
//  mem_wdata_i   in   32  write data
//  mem_we_i      in   1   1 = write, 0 = read
//  mem_req_i     in   1   request; held high until granted
//  mem_be_i      in   4   byte enables; be[n] covers wdata[8n+7:8n]
//  mem_rdata_o   out  32  read data; valid while mem_rvalid_o is high
//  mem_gnt_o     out  1   grant; the request is accepted when req and gnt are both high
//  mem_rvalid_o  out  1   one-cycle response pulse, for reads and writes
//  mem_error_o   out  1   out-of-range access flag, qualified by rvalid (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): state IDLE; rvalid_o=0, rdata_o=0, error_o=0.
//    gnt_o is forced to 0 while reset is low. RAM contents are not reset.
//  - States: IDLE, GNT_WAIT, RESP_WAIT. At most one transaction is outstanding.
//  - IDLE:
//    - GNT_LATENCY==0: gnt_o = req_i (combinational). On grant, go to RESP_WAIT.
//    - GNT_LATENCY>0: on req_i, load cnt=GNT_LATENCY-1 and go to GNT_WAIT.
//  - GNT_WAIT:
//    - req_i low: return to IDLE; the request is withdrawn, with no access and no response.
//    - cnt!=0: decrement cnt.
//    - cnt==0: gnt_o=1 this cycle; go to RESP_WAIT.
//  - Grant cycle: addr, we, be and wdata are sampled at the closing edge.
//    - A write commits to the RAM at that same edge.
//    - A read captures the RAM word at that same edge.
//  - RESP_WAIT: load cnt=RVALID_LATENCY-1 on entry and count down.
//    - rvalid_o is registered and high exactly RVALID_LATENCY cycles after the grant cycle, for one cycle.
//    - The state returns to IDLE on the rvalid cycle.
//  - gnt_o is never high in RESP_WAIT. The earliest next grant is the cycle after rvalid_o.
//  - rdata_o:
//    - Reads: the captured word.
//    - Writes: 32'h0.
//    - Held stable until the next rvalid.
//  - Address decode: idx = (addr - BASE_ADDR) >> 2.
//    - In range when addr >= BASE_ADDR and idx < DEPTH_WORDS. No wrap-around.
//  - Out-of-range access: read returns 0; write is dropped; rvalid is still produced.
//  - Writes are byte-masked per be_i. be_i==4'b0000 leaves the word unchanged and still responds.
//  - Reset mid-transaction aborts it and no rvalid is issued. A write granted before reset stays committed.
// CONFIGURATION
//  CACHE_MEM_RESP_ERROR_EN
//  - Defined: error_o=1 together with rvalid_o for an out-of-range access, else 0.
//  - Undefined: error_o is tied to 0. The out-of-range data behaviour is unchanged.
// STRUCTURE
//  - Package cache_mem_resp_pkg:
//    - state enum resp_state_e {IDLE, GNT_WAIT, RESP_WAIT}
//    - counter-width function cnt_w(GNT_LATENCY, RVALID_LATENCY)
//    - BYTES_PER_WORD=4
//  - Sub-module cache_mem_resp_ram: single-port DEPTH_WORDS x 32 RAM with 4 byte-write enables and a registered read.
//  - The top level holds the FSM, counters, decode and error logic.
// TESTING
//  1. Write: addr=BASE+0x10, wdata=0xDEADBEEF, be=4'hF, then a read of the same address
//     -> rdata=0xDEADBEEF; rvalid exactly RVALID_LATENCY cycles after the read grant; error=0.
//  2. Write: be=4'b0101, wdata=0x11223344 over 0xDEADBEEF, then a read
//     -> rdata=0xDE22BE44. Write rvalid carries rdata=0.
//  3. GNT_LATENCY=3, req held -> gnt high on the 4th cycle of req.
//     Separately, req dropped after 2 cycles -> no gnt, no rvalid, RAM unchanged.
//  4. Read at BASE+4*DEPTH_WORDS
//     -> rvalid, rdata=0; error=1 with CACHE_MEM_RESP_ERROR_EN defined, error=0 without.
//     Write to the same address -> no RAM word changes.
//  5. req held high across two back-to-back reads
//     -> second gnt no earlier than the cycle after the first rvalid; no overlap.
//  6. reset low during RESP_WAIT (RVALID_LATENCY=4)
//     -> no rvalid; outputs 0; a subsequent read works normally.

Source files
------------

// File: rtl/cache_mem_resp_pkg.sv
// Shared types and sizing helpers for the cache memory-side responder.
package cache_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_WAIT  = 2'd1,
        RESP_WAIT = 2'd2
    } resp_state_e;

    localparam int unsigned BYTES_PER_WORD = 32'd4;

    // Counter must hold max(latency)-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned gnt_lat, input int unsigned rv_lat);
        int unsigned max_v;
        max_v = (gnt_lat > rv_lat) ? gnt_lat : rv_lat;
        return (max_v > 32'd2) ? $clog2(max_v) : 32'd1;
    endfunction

endpackage

// File: rtl/cache_mem_resp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module cache_mem_resp_ram
    import cache_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [BYTES_PER_WORD-1:0] be,
    input  logic [IDX_W-1:0]          idx,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Byte-masked write or word read, both on the accepting edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BYTES_PER_WORD; b++) begin
                    if (be[b]) begin
                        mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_r <= mem_r[idx];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache req/gnt/rvalid port with configurable grant/response latency.
// Optional out-of-range error reporting is enabled by defining CACHE_MEM_RESP_ERROR_EN.
module cache_mem_responder
    import cache_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned GNT_LATENCY    = 0,
    parameter int unsigned RVALID_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_we_i,
    input  logic        mem_req_i,
    input  logic [3:0]  mem_be_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_gnt_o,
    output logic        mem_rvalid_o,
    output logic        mem_error_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;
    localparam int unsigned CNT_W = cnt_w(GNT_LATENCY, RVALID_LATENCY);

    resp_state_e      state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             gnt_s, accept_s, in_range_s, rvalid_nxt_s, err_nxt_s;
    logic [31:0]      off_s, ram_q_s, resp_data_s, hold_r;
    logic             txn_we_r, txn_oor_r, rvalid_r, err_r;

    // Word offset from the base; addresses below the base wrap high and fail the range test.
    assign off_s      = (mem_addr_i - BASE_ADDR) >> 2'd2;
    assign in_range_s = (mem_addr_i >= BASE_ADDR) && (off_s < DEPTH_WORDS);
    assign accept_s   = gnt_s & mem_req_i;

    // Next-state, counter and grant decode; grant is suppressed while reset is asserted.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        gnt_s       = 1'b0;
        if (!reset) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!mem_req_i) begin
                        state_nxt_s = IDLE;
                    end else if (GNT_LATENCY == 32'd0) begin
                        gnt_s       = 1'b1;
                        state_nxt_s = RESP_WAIT;
                        cnt_nxt_s   = CNT_W'(RVALID_LATENCY - 32'd1);
                    end else begin
                        state_nxt_s = GNT_WAIT;
                        cnt_nxt_s   = CNT_W'(GNT_LATENCY - 32'd1);
                    end
                end
                GNT_WAIT: begin
                    if (!mem_req_i) begin
                        state_nxt_s = IDLE;
                    end else if (cnt_r != '0) begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end else begin
                        gnt_s       = 1'b1;
                        state_nxt_s = RESP_WAIT;
                        cnt_nxt_s   = CNT_W'(RVALID_LATENCY - 32'd1);
                    end
                end
                RESP_WAIT: begin
                    if (cnt_r == '0) begin
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // The response cycle is the last RESP_WAIT cycle, so the next grant can only follow it.
    assign rvalid_nxt_s = (state_nxt_s == RESP_WAIT) && (cnt_nxt_s == '0);

`ifdef CACHE_MEM_RESP_ERROR_EN
    logic oor_nxt_s;
    assign oor_nxt_s = accept_s ? ~in_range_s : txn_oor_r;
    assign err_nxt_s = rvalid_nxt_s & oor_nxt_s;
`else
    assign err_nxt_s = 1'b0;
`endif

    cache_mem_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (accept_s & in_range_s),
        .we    (mem_we_i),
        .be    (mem_be_i),
        .idx   (off_s[IDX_W-1:0]),
        .wdata (mem_wdata_i),
        .rdata (ram_q_s)
    );

    // FSM state, transaction attributes and registered response flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            txn_we_r  <= 1'b0;
            txn_oor_r <= 1'b0;
            rvalid_r  <= 1'b0;
            err_r     <= 1'b0;
            hold_r    <= 32'h0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rvalid_r <= rvalid_nxt_s;
            err_r    <= err_nxt_s;
            if (accept_s) begin
                txn_we_r  <= mem_we_i;
                txn_oor_r <= ~in_range_s;
            end
            if (rvalid_r) begin
                hold_r <= resp_data_s;
            end
        end
    end

    // The RAM read register may be overwritten by the next read, so the response is held separately.
    assign resp_data_s  = (txn_we_r || txn_oor_r) ? 32'h0 : ram_q_s;
    assign mem_rdata_o  = rvalid_r ? resp_data_s : hold_r;
    assign mem_gnt_o    = gnt_s;
    assign mem_rvalid_o = rvalid_r;
    assign mem_error_o  = err_r;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench: dut0 uses zero grant / unit response latency, dut1 uses GNT_LATENCY=3, RVALID_LATENCY=4.
module tb_cache_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 64;
`ifdef CACHE_MEM_RESP_ERROR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic        req0, gnt0, rvalid0, err0;
    logic        req1, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    cache_mem_responder #(
        .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_LATENCY(0), .RVALID_LATENCY(1)
    ) dut0 (
        .clk(clk), .reset(reset), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_we_i(mem_we), .mem_req_i(req0), .mem_be_i(mem_be), .mem_rdata_o(rdata0),
        .mem_gnt_o(gnt0), .mem_rvalid_o(rvalid0), .mem_error_o(err0)
    );

    cache_mem_responder #(
        .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_LATENCY(3), .RVALID_LATENCY(4)
    ) dut1 (
        .clk(clk), .reset(reset), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_we_i(mem_we), .mem_req_i(req1), .mem_be_i(mem_be), .mem_rdata_o(rdata1),
        .mem_gnt_o(gnt1), .mem_rvalid_o(rvalid1), .mem_error_o(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after rvalid (or after a timeout).
    task automatic do_txn(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input bit keep,
                          output logic [31:0] rdata, output logic err,
                          output int gnt_wait, output int rv_lat, output bit overlap);
        bit done;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_we    = we;
        mem_be    = be;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        gnt_wait = -1;
        rv_lat   = -1;
        overlap  = 1'b0;
        rdata    = 'x;
        err      = 1'bx;
        done     = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (sel ? gnt1 : gnt0) begin
                gnt_wait = n;
                done     = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!keep || !done) begin
            if (sel) req1 = 1'b0; else req0 = 1'b0;
        end
        for (int k = 1; k <= 40 && done && rv_lat < 0; k++) begin
            #1;
            if (sel ? gnt1 : gnt0) overlap = 1'b1;
            if (sel ? rvalid1 : rvalid0) begin
                rv_lat = k;
                rdata  = sel ? rdata1 : rdata0;
                err    = sel ? err1 : err0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          gw, rl;
        bit          ov, seen;

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_we = 1'b0; mem_be = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        req0 = 1'b1;
        #1;
        chk("rst_gnt_forced", 32'(gnt0), 32'd0);
        req0  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full write then read-back, zero grant latency
        do_txn(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("wr_gnt_wait", 32'(gw), 32'd0);
        chk("wr_rv_lat", 32'(rl), 32'd1);
        chk("wr_rdata_zero", rd, 32'h0);
        chk("wr_err", 32'(er), 32'd0);
        do_txn(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_rv_lat", 32'(rl), 32'd1);
        chk("rd_err", 32'(er), 32'd0);

        // Byte-masked write
        do_txn(1'b0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'b0101, 1'b0, rd, er, gw, rl, ov);
        chk("be_wr_rdata_zero", rd, 32'h0);
        do_txn(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("be_rd_data", rd, 32'hDE22_BE44);

        // Last in-range word and a be=0 write
        do_txn(1'b0, 1'b1, BASE, 32'h0123_4567, 4'hF, 1'b0, rd, er, gw, rl, ov);
        do_txn(1'b0, 1'b1, BASE + 32'hFC, 32'hCAFE_F00D, 4'hF, 1'b0, rd, er, gw, rl, ov);
        do_txn(1'b0, 1'b1, BASE + 32'hFC, 32'h0, 4'h0, 1'b0, rd, er, gw, rl, ov);
        chk("be0_rv_lat", 32'(rl), 32'd1);
        do_txn(1'b0, 1'b0, BASE + 32'hFC, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("last_word_data", rd, 32'hCAFE_F00D);
        chk("last_word_err", 32'(er), 32'd0);

        // Out of range: one past the end and one below the base
        do_txn(1'b0, 1'b0, BASE + 32'h100, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("oor_rd_lat", 32'(rl), 32'd1);
        chk("oor_rd_data", rd, 32'h0);
        chk("oor_rd_err", 32'(er), 32'(ERR_EN));
        do_txn(1'b0, 1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("oor_wr_err", 32'(er), 32'(ERR_EN));
        do_txn(1'b0, 1'b0, BASE, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("oor_no_wrap", rd, 32'h0123_4567);
        do_txn(1'b0, 1'b0, BASE - 32'h4, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("below_base_data", rd, 32'h0);
        chk("below_base_err", 32'(er), 32'(ERR_EN));

        // Back-to-back reads with req held high
        do_txn(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b1, rd, er, gw, rl, ov);
        chk("b2b_first_data", rd, 32'hDE22_BE44);
        chk("b2b_no_overlap", 32'(ov), 32'd0);
        do_txn(1'b0, 1'b0, BASE, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("b2b_second_gnt", 32'(gw), 32'd0);
        chk("b2b_second_data", rd, 32'h0123_4567);

        // Grant latency 3, response latency 4
        do_txn(1'b1, 1'b1, BASE + 32'h20, 32'hAAAA_AAAA, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("gl3_wr_gnt_wait", 32'(gw), 32'd3);
        chk("gl3_wr_rv_lat", 32'(rl), 32'd4);
        do_txn(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("gl3_rd_data", rd, 32'hAAAA_AAAA);
        chk("gl3_rd_rv_lat", 32'(rl), 32'd4);

        // Request withdrawn after two cycles
        mem_addr = BASE + 32'h20; mem_wdata = 32'h5555_5555; mem_we = 1'b1; mem_be = 4'hF;
        req1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (gnt1) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (gnt1 || rvalid1) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("withdraw_quiet", 32'(seen), 32'd0);
        do_txn(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("withdraw_ram_kept", rd, 32'hAAAA_AAAA);

        // Reset while dut1 is waiting to respond
        mem_addr = BASE + 32'h20; mem_we = 1'b0;
        req1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (gnt1) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mid_rst_granted", 32'(seen), 32'd1);
        req1 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req0  = 1'b1;
        #1;
        chk("mid_rst_gnt_forced", 32'(gnt0), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_rvalid", 32'(rvalid1), 32'd0);
        chk("mid_rst_rdata", rdata1, 32'h0);
        chk("mid_rst_err", 32'(err1), 32'd0);
        reset = 1'b1;
        req0  = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rvalid1) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mid_rst_no_rvalid", 32'(seen), 32'd0);
        do_txn(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, rd, er, gw, rl, ov);
        chk("post_rst_data", rd, 32'hAAAA_AAAA);
        chk("post_rst_rv_lat", 32'(rl), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
